// File: rtl/divider_32by16_seq.sv
// Sequential restoring divider: 2*DW-bit dividend / DW-bit divisor, one quotient bit per clock.
// Define DIV_OVF_CHECK_EN to build the quotient-overflow flag; otherwise ovf_o is tied low.
module divider_32by16_seq #(
  parameter int DW = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2*DW-1:0] n_i,
  input  logic [DW-1:0]   d_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [2*DW-1:0] q_o,
  output logic [DW-1:0]   r_o,
  output logic            dbz_o,
  output logic            ovf_o
);

  localparam int CW = $clog2(2 * DW);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [DW-1:0]     pr_q;
  logic [2*DW-1:0]   nsh_q;
  logic [2*DW-1:0]   qsh_q;
  logic [DW-1:0]     d_q;
  logic              busy_q;
  logic              done_q;
  logic [2*DW-1:0]   q_q;
  logic [DW-1:0]     r_q;
  logic              dbz_q;

  logic [DW:0]       t_d;
  logic              ge_d;
  logic [DW-1:0]     pr_d;
  logic [2*DW-1:0]   qsh_d;

  // One restoring step. pr[DW] is always 0 after a step, so only DW bits are stored;
  // the DW-bit modular subtract is exact whenever t >= d.
  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    t_d   = {pr_q, nsh_q[2*DW-1]};
    ge_d  = (t_d >= {1'b0, d_q});
    pr_d  = t_d[DW-1:0];
    if (ge_d) pr_d = t_d[DW-1:0] - d_q;
    qsh_d = {qsh_q[2*DW-2:0], ge_d};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pr_q    <= '0;
      nsh_q   <= '0;
      qsh_q   <= '0;
      d_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          pr_q  <= pr_d;
          nsh_q <= {nsh_q[2*DW-2:0], 1'b0};
          qsh_q <= qsh_d;
          if (cnt_q == '0) begin
            state_q <= FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            q_q     <= qsh_d;
            r_q     <= pr_d;
            dbz_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        IDLE, FIN: begin
          // FIN accepts a new start exactly like IDLE, allowing back-to-back issue.
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          if (start_i) begin
            if (d_i != '0) begin
              state_q <= RUN;
              busy_q  <= 1'b1;
              cnt_q   <= CW'(2 * DW - 1);
              pr_q    <= '0;
              nsh_q   <= n_i;
              qsh_q   <= '0;
              d_q     <= d_i;
            end else begin
              state_q <= FIN;
              done_q  <= 1'b1;
              q_q     <= '1;
              r_q     <= n_i[DW-1:0];
              dbz_q   <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef DIV_OVF_CHECK_EN
  logic ovf_q;

  // Flags a quotient wider than DW bits; a divide-by-zero quotient is all ones, so it flags too.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovf_q <= 1'b0;
    end else if (state_q == RUN && cnt_q == '0) begin
      ovf_q <= |qsh_d[2*DW-1:DW];
    end else if (state_q != RUN && start_i && d_i == '0) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf_o = ovf_q;
`else
  assign ovf_o = 1'b0;
`endif

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign q_o    = q_q;
  assign r_o    = r_q;
  assign dbz_o  = dbz_q;

endmodule
